// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access/writeback stage: FSM states, op-kind
// classification of an incoming execute op, and reset constants.
package mem_stage_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  typedef enum logic [1:0] {
    OP_ALU,
    OP_LOAD,
    OP_STORE,
    OP_ILLEGAL
  } op_kind_t;

  localparam state_t RST_STATE = ST_IDLE;
  localparam logic   RST_FLAG  = 1'b0;

  // Decide what the stage does with an op: register-only, load, store or abort.
  // Alignment only matters for ops that actually touch memory.
  function automatic op_kind_t classify(input logic       rd,
                                        input logic       wr,
                                        input logic [1:0] addr_lo);
    if (rd && wr)            return OP_ILLEGAL;
    if (!rd && !wr)          return OP_ALU;
    if (addr_lo != 2'b00)    return OP_ILLEGAL;
    return rd ? OP_LOAD : OP_STORE;
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Bus bundle for mem_wb_stage: execute handshake, data-memory request/ack and
// register-file writeback. master = the stage, slave = its environment.
interface mem_wb_stage_if #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int REG_IDX_W = 3
);
  logic                 ex_valid;
  logic                 ex_ready;
  logic [DATA_W:0]      ex_result;
  logic [REG_IDX_W-1:0] ex_dest_reg;
  logic                 ex_w_enable;
  logic                 ex_mem_read;
  logic                 ex_mem_write;
  logic [ADDR_W-1:0]    ex_mem_addr;
  logic [DATA_W-1:0]    ex_mem_wdata;

  logic                 dmem_req;
  logic                 dmem_we;
  logic [ADDR_W-1:0]    dmem_addr;
  logic [DATA_W-1:0]    dmem_wdata;
  logic [DATA_W-1:0]    dmem_rdata;
  logic                 dmem_ack;

  logic                 wb_valid;
  logic                 wb_w_enable;
  logic [REG_IDX_W-1:0] wb_dest_reg;
  logic [DATA_W-1:0]    wb_data;
  logic                 mem_err;

  modport master (
    input  ex_valid, ex_result, ex_dest_reg, ex_w_enable, ex_mem_read,
           ex_mem_write, ex_mem_addr, ex_mem_wdata, dmem_rdata, dmem_ack,
    output ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           wb_valid, wb_w_enable, wb_dest_reg, wb_data, mem_err
  );

  modport slave (
    output ex_valid, ex_result, ex_dest_reg, ex_w_enable, ex_mem_read,
           ex_mem_write, ex_mem_addr, ex_mem_wdata, dmem_rdata, dmem_ack,
    input  ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           wb_valid, wb_w_enable, wb_dest_reg, wb_data, mem_err
  );
endinterface

// File: rtl/mem_timeout_ctr.sv
// Counts BUSY cycles without a memory ack; expired is asserted combinationally
// in the cycle that would bring the count to TIMEOUT_CYCLES, so the request is
// held for exactly TIMEOUT_CYCLES cycles before the abort takes effect.
module mem_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int unsigned    CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]  TOP  = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count_q;

  // Cycle counter: cleared on entry to BUSY, saturates at TIMEOUT_CYCLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         count_q <= '0;
    else if (clear)                     count_q <= '0;
    else if (enable && count_q != TOP)  count_q <= count_q + CW'(1);
  end

  assign expired = enable && (count_q == LAST);
endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access/writeback stage. ALU/move ops go straight to writeback; loads
// and stores run one request on the data-memory bus and stall execute until
// acknowledged. Optional abort of a stuck access under `MEM_TIMEOUT_EN.
// Interface parameters must match the module's ADDR_W/DATA_W/REG_IDX_W.
module mem_wb_stage
  import mem_stage_pkg::*;
#(
  parameter int          ADDR_W         = 32,
  parameter int          DATA_W         = 32,
  parameter int          REG_IDX_W      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_wb_stage_if.master  bus
);
  state_t               state_q, state_d;
  op_kind_t             kind;
  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [REG_IDX_W-1:0] pend_dest_q, pend_dest_d;
  logic                 wb_valid_q, wb_valid_d;
  logic                 wb_we_q, wb_we_d;
  logic [REG_IDX_W-1:0] wb_dest_q, wb_dest_d;
  logic [DATA_W-1:0]    wb_data_q, wb_data_d;
  logic                 err_q, err_d;
  logic                 mem_accept;
  logic                 timeout_hit;
  logic                 unused_carry;

  assign unused_carry = bus.ex_result[DATA_W];
  assign kind         = classify(bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_addr[1:0]);
  assign mem_accept   = (state_q == ST_IDLE) && bus.ex_valid &&
                        ((kind == OP_LOAD) || (kind == OP_STORE));

`ifdef MEM_TIMEOUT_EN
  mem_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (mem_accept),
    .enable  ((state_q == ST_BUSY) && !bus.dmem_ack),
    .expired (timeout_hit)
  );
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RST_STATE;
    else        state_q <= state_d;
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    pend_dest_d = pend_dest_q;
    wb_valid_d  = 1'b0;
    wb_we_d     = 1'b0;
    wb_dest_d   = wb_dest_q;
    wb_data_d   = wb_data_q;
    err_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.ex_valid) begin
          unique case (kind)
            OP_ALU: begin
              wb_valid_d = 1'b1;
              wb_we_d    = bus.ex_w_enable;
              wb_dest_d  = bus.ex_dest_reg;
              wb_data_d  = bus.ex_result[DATA_W-1:0];
            end
            OP_ILLEGAL: begin
              wb_valid_d = 1'b1;
              err_d      = 1'b1;
              wb_dest_d  = bus.ex_dest_reg;
              wb_data_d  = '0;
            end
            default: begin
              state_d     = ST_BUSY;
              req_d       = 1'b1;
              we_d        = (kind == OP_STORE);
              addr_d      = bus.ex_mem_addr;
              wdata_d     = bus.ex_mem_wdata;
              pend_dest_d = bus.ex_dest_reg;
            end
          endcase
        end
      end
      ST_BUSY: begin
        if (req_q && bus.dmem_ack) begin
          state_d    = ST_IDLE;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_we_d    = !we_q;
          wb_dest_d  = pend_dest_q;
          wb_data_d  = we_q ? '0 : bus.dmem_rdata;
        end else if (timeout_hit) begin
          state_d    = ST_IDLE;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          err_d      = 1'b1;
          wb_dest_d  = pend_dest_q;
          wb_data_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered bus and writeback outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q       <= RST_FLAG;
      we_q        <= RST_FLAG;
      addr_q      <= '0;
      wdata_q     <= '0;
      pend_dest_q <= '0;
      wb_valid_q  <= RST_FLAG;
      wb_we_q     <= RST_FLAG;
      wb_dest_q   <= '0;
      wb_data_q   <= '0;
      err_q       <= RST_FLAG;
    end else begin
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      pend_dest_q <= pend_dest_d;
      wb_valid_q  <= wb_valid_d;
      wb_we_q     <= wb_we_d;
      wb_dest_q   <= wb_dest_d;
      wb_data_q   <= wb_data_d;
      err_q       <= err_d;
    end
  end

  assign bus.ex_ready    = (state_q == ST_IDLE);
  assign bus.dmem_req    = req_q;
  assign bus.dmem_we     = we_q;
  assign bus.dmem_addr   = addr_q;
  assign bus.dmem_wdata  = wdata_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_w_enable = wb_we_q;
  assign bus.wb_dest_reg = wb_dest_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.mem_err     = err_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed cases then random ops, checked against
// a transaction-level model (op rules + sparse memory array).
// Define MEM_TIMEOUT_EN to build and check the timeout variant (TIMEOUT_CYCLES=4).
module tb_mem_wb_stage;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RW = 3;
`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TO    = 4;
  localparam bit          TO_EN = 1'b1;
`else
  localparam int unsigned TO    = 16;
  localparam bit          TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_wb_stage_if #(.ADDR_W(AW), .DATA_W(DW), .REG_IDX_W(RW)) bus ();

  mem_wb_stage #(
    .ADDR_W(AW), .DATA_W(DW), .REG_IDX_W(RW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [DW-1:0] mem_model [logic [AW-1:0]];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock with no op; any ack here arrives while no request is pending.
  task automatic idle_cycle(input bit spurious_ack);
    bus.dmem_ack   = spurious_ack;
    bus.dmem_rdata = $urandom;
    @(posedge clk); #1;
    bus.dmem_ack = 1'b0;
    check("idle_wb_valid", bus.wb_valid, 0);
    check("idle_dmem_req", bus.dmem_req, 0);
    check("idle_mem_err",  bus.mem_err,  0);
    check("idle_ready",    bus.ex_ready, 1);
  endtask

  // Issue one op at posedge+1, follow it to its writeback strobe and check.
  task automatic run_op(input logic [DW:0] result, input logic [RW-1:0] dest,
                        input logic w_en, input logic rd, input logic wr,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int unsigned ack_delay);
    bit illegal, is_mem, timeout;
    int unsigned last;
    logic [DW-1:0] rdata;
    logic [DW-1:0] res_lo;
    illegal = (rd && wr) || ((rd || wr) && (addr % 4 != 0));
    is_mem  = (rd || wr) && !illegal;
    res_lo  = result[DW-1:0];
    check("accept_ready", bus.ex_ready, 1);
    bus.ex_valid     = 1'b1;
    bus.ex_result    = result;
    bus.ex_dest_reg  = dest;
    bus.ex_w_enable  = w_en;
    bus.ex_mem_read  = rd;
    bus.ex_mem_write = wr;
    bus.ex_mem_addr  = addr;
    bus.ex_mem_wdata = wdata;
    @(posedge clk); #1;
    bus.ex_valid     = 1'b0;
    bus.ex_result    = {1'($urandom), 32'($urandom)};
    bus.ex_mem_read  = 1'($urandom);
    bus.ex_mem_write = 1'($urandom);
    if (!is_mem) begin
      check("nomem_req",     bus.dmem_req,    0);
      check("nomem_wb",      bus.wb_valid,    1);
      check("nomem_err",     bus.mem_err,     illegal);
      check("nomem_wen",     bus.wb_w_enable, illegal ? 1'b0 : w_en);
      check("nomem_dest",    bus.wb_dest_reg, dest);
      if (!illegal) check("alu_data", bus.wb_data, res_lo);
    end else begin
      rdata   = mem_model.exists(addr) ? mem_model[addr] : DW'($urandom);
      timeout = TO_EN && (ack_delay > TO - 1);
      last    = timeout ? TO - 1 : ack_delay;
      for (int unsigned c = 0; c <= last; c++) begin
        check("busy_req",   bus.dmem_req,  1);
        check("busy_we",    bus.dmem_we,   wr);
        check("busy_addr",  bus.dmem_addr, addr);
        if (wr) check("busy_wdata", bus.dmem_wdata, wdata);
        check("busy_ready", bus.ex_ready,  0);
        check("busy_wb",    bus.wb_valid,  0);
        if (c == last && !timeout) begin
          bus.dmem_ack   = 1'b1;
          bus.dmem_rdata = rdata;
        end else begin
          bus.dmem_rdata = $urandom;
        end
        @(posedge clk); #1;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = $urandom;
      end
      check("done_req",   bus.dmem_req, 0);
      check("done_wb",    bus.wb_valid, 1);
      check("done_ready", bus.ex_ready, 1);
      check("done_err",   bus.mem_err,  timeout);
      if (timeout) begin
        check("to_wen", bus.wb_w_enable, 0);
      end else if (rd) begin
        check("ld_wen",  bus.wb_w_enable, 1);
        check("ld_data", bus.wb_data,     rdata);
        check("ld_dest", bus.wb_dest_reg, dest);
        mem_model[addr] = rdata;
      end else begin
        check("st_wen",  bus.wb_w_enable, 0);
        check("st_data", bus.wb_data,     0);
        mem_model[addr] = wdata;
      end
    end
  endtask

  task automatic reset_mid_busy();
    check("rb_ready", bus.ex_ready, 1);
    bus.ex_valid     = 1'b1;
    bus.ex_mem_read  = 1'b1;
    bus.ex_mem_write = 1'b0;
    bus.ex_mem_addr  = 32'h80;
    @(posedge clk); #1;
    bus.ex_valid = 1'b0;
    check("rb_req_on", bus.dmem_req, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rb_req_off", bus.dmem_req,  0);
    check("rb_ready1",  bus.ex_ready,  1);
    check("rb_wb",      bus.wb_valid,  0);
    check("rb_addr",    bus.dmem_addr, 0);
    check("rb_err",     bus.mem_err,   0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rb_wb_after", bus.wb_valid, 0);
  endtask

  initial begin
    logic [AW-1:0] a;
    int unsigned   sel;
    rst_n            = 1'b0;
    bus.ex_valid     = 1'b0;
    bus.ex_result    = '0;
    bus.ex_dest_reg  = '0;
    bus.ex_w_enable  = 1'b0;
    bus.ex_mem_read  = 1'b0;
    bus.ex_mem_write = 1'b0;
    bus.ex_mem_addr  = '0;
    bus.ex_mem_wdata = '0;
    bus.dmem_rdata   = '0;
    bus.dmem_ack     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", bus.ex_ready,    1);
    check("rst_req",   bus.dmem_req,    0);
    check("rst_we",    bus.dmem_we,     0);
    check("rst_addr",  bus.dmem_addr,   0);
    check("rst_wdata", bus.dmem_wdata,  0);
    check("rst_wb",    bus.wb_valid,    0);
    check("rst_wen",   bus.wb_w_enable, 0);
    check("rst_dest",  bus.wb_dest_reg, 0);
    check("rst_data",  bus.wb_data,     0);
    check("rst_err",   bus.mem_err,     0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    run_op(33'h1_0000_0005, 3'd3, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 0);
    idle_cycle(1'b0);
    mem_model[32'h40] = 32'hDEADBEEF;
    run_op('0, 3'd5, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 3);
    run_op('0, 3'd1, 1'b0, 1'b0, 1'b1, 32'h44, 32'h1234, 0);
    idle_cycle(1'b1);
    run_op('0, 3'd2, 1'b1, 1'b1, 1'b0, 32'h42, 32'h0, 0);
    run_op('0, 3'd4, 1'b1, 1'b1, 1'b1, 32'h48, 32'h0, 0);
    idle_cycle(1'b0);
    if (TO_EN) begin
      run_op('0, 3'd6, 1'b1, 1'b1, 1'b0, 32'h50, 32'h0, TO + 2);
      run_op('0, 3'd6, 1'b1, 1'b1, 1'b0, 32'h54, 32'h0, TO - 1);
    end
    reset_mid_busy();
    run_op(33'h0_0000_0077, 3'd7, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 0);
    run_op('0, 3'd0, 1'b0, 1'b0, 1'b1, 32'h44, 32'h5555, 1);
    run_op('0, 3'd2, 1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 2);

    // Random ops over a small address window so loads revisit stores.
    for (int unsigned i = 0; i < 120; i++) begin
      sel = $urandom_range(0, 9);
      a   = {26'h0, 4'($urandom), 2'b00};
      if (sel < 4) begin
        run_op({1'($urandom), 32'($urandom)}, 3'($urandom), 1'($urandom),
               1'b0, 1'b0, a, 32'($urandom), 0);
      end else if (sel < 6) begin
        run_op('0, 3'($urandom), 1'($urandom), 1'b1, 1'b0, a, 32'($urandom),
               $urandom_range(0, TO_EN ? TO + 1 : 5));
      end else if (sel < 8) begin
        run_op('0, 3'($urandom), 1'($urandom), 1'b0, 1'b1, a, 32'($urandom),
               $urandom_range(0, TO_EN ? TO + 1 : 5));
      end else if (sel == 8) begin
        run_op('0, 3'($urandom), 1'b1, 1'($urandom), 1'b1, a | 32'($urandom_range(1, 3)),
               32'($urandom), 0);
      end else begin
        run_op('0, 3'($urandom), 1'b1, 1'b1, 1'b1, a, 32'($urandom), 0);
      end
      if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
